// File: rtl/dtree_feature_loader_if.sv
// rtl/dtree_feature_loader_if.sv - feature byte stream and class result handshake bundle (m_err present with DTREE_LOADER_CLASS_CHECK_EN)
interface dtree_feature_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       m_valid;
    logic [3:0] m_class;
    logic       m_ready;
`ifdef DTREE_LOADER_CLASS_CHECK_EN
    logic       m_err;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_class, m_err
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_class, m_err
    );
`else
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_class
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_class
    );
`endif
endinterface

// File: rtl/dtree_feature_loader.sv
// rtl/dtree_feature_loader.sv - loads NFEAT feature bytes, waits for the classifier to settle, holds the class result (optional m_err via DTREE_LOADER_CLASS_CHECK_EN)
module dtree_feature_loader #(
    parameter int NFEAT  = 16,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    dtree_feature_loader_if.slave bus,
    output logic [NFEAT*8-1:0]   feat_vec,
    input  logic [3:0]           cls_in
);

    localparam int              IDX_W    = (NFEAT > 1) ? $clog2(NFEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFEAT - 1);
    localparam logic [3:0]      CNT_INIT = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [3:0]         r_cnt;
    logic               r_smp;
    logic [NFEAT*8-1:0] r_feat;
    logic [3:0]         r_class;
    logic               r_valid;
    logic               r_err;

    logic               w_s_fire;
    logic               w_m_fire;
    logic               w_last;

    assign w_s_fire = bus.s_valid && (r_state == ST_LOAD);
    assign w_m_fire = r_valid && bus.m_ready;
    assign w_last   = (r_idx == LAST_IDX);

    assign bus.s_ready = (r_state == ST_LOAD);
    assign bus.m_valid = r_valid;
    assign bus.m_class = r_class;
    assign feat_vec    = r_feat;

`ifdef DTREE_LOADER_CLASS_CHECK_EN
    assign bus.m_err = r_err;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:   if (w_s_fire && w_last) w_next = ST_SETTLE;
                ST_SETTLE: if (r_smp)              w_next = ST_HOLD;
                ST_HOLD:   if (w_m_fire)           w_next = ST_LOAD;
                default:                           w_next = ST_LOAD;
            endcase
        end
    end

    // Feature capture, settle countdown and result registers.
    // The count runs SETTLE-1 down to 0; r_smp marks the cycle after the
    // count has reached zero, and cls_in is sampled on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_smp   <= 1'b0;
            r_feat  <= '0;
            r_class <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (flush) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_smp   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (w_s_fire) begin
                for (int i = 0; i < NFEAT; i++) begin
                    if (r_idx == IDX_W'(i)) begin
                        r_feat[8*i +: 8] <= bus.s_data;
                    end
                end
                if (w_last) begin
                    r_idx <= '0;
                    r_cnt <= CNT_INIT;
                    r_smp <= 1'b0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end

            if (r_state == ST_SETTLE) begin
                if (r_smp) begin
                    r_class <= cls_in;
                    r_err   <= (cls_in > 4'd9);
                    r_valid <= 1'b1;
                    r_smp   <= 1'b0;
                end else if (r_cnt == 4'd0) begin
                    r_smp <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            if ((r_state == ST_HOLD) && w_m_fire) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifndef DTREE_LOADER_CLASS_CHECK_EN
    logic w_unused;
    assign w_unused = r_err;
`endif

endmodule

// File: tb/tb_dtree_feature_loader.sv
// tb/tb_dtree_feature_loader.sv - directed self-checking bench for dtree_feature_loader
module tb_dtree_feature_loader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [3:0]   cls_in = 4'd0;
    logic [127:0] feat_vec;

    int checks = 0;
    int errors = 0;

    dtree_feature_loader_if bus();

    dtree_feature_loader #(.NFEAT(16), .SETTLE(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .feat_vec (feat_vec),
        .cls_in   (cls_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ramp(input logic [7:0] base);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = base + 8'(k);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = base + 8'(i);
            tick();
        end
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
    endtask

    task automatic wait_mvalid(input string tag);
        int n;
        n = 0;
        while (!bus.m_valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, 128'(bus.m_valid), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int cyc;
        int v;

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b1;

        // reset state
        #1;
        check("rst_m_valid", 128'(bus.m_valid), 128'd0);
        check("rst_m_class", 128'(bus.m_class), 128'd0);
        check("rst_feat",    feat_vec,          128'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_s_ready", 128'(bus.s_ready), 128'd1);

        // stream 0x00..0x0F, latency of three edges after last byte
        cls_in = 4'd4;
        send_seq(8'h00, 16);
        check("lat_t0_m_valid", 128'(bus.m_valid), 128'd0);
        check("lat_t0_s_ready", 128'(bus.s_ready), 128'd0);
        tick();
        check("lat_t1_m_valid", 128'(bus.m_valid), 128'd0);
        tick();
        check("lat_t2_m_valid", 128'(bus.m_valid), 128'd0);
        tick();
        check("lat_t3_m_valid", 128'(bus.m_valid), 128'd1);
        check("lat_t3_m_class", 128'(bus.m_class), 128'd4);
        check("lat_feat",       feat_vec,          ramp(8'h00));
        tick();
        check("pulse_m_valid_low", 128'(bus.m_valid), 128'd0);
        check("pulse_s_ready",     128'(bus.s_ready), 128'd1);

        // hold with m_ready low, cls_in changing, stray s_valid ignored
        bus.m_ready = 1'b0;
        cls_in = 4'd4;
        send_seq(8'h00, 16);
        wait_mvalid("hold_wait");
        cls_in = 4'd7;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h77;
        repeat (10) tick();
        check("hold_m_class", 128'(bus.m_class), 128'd4);
        check("hold_m_valid", 128'(bus.m_valid), 128'd1);
        check("hold_s_ready", 128'(bus.s_ready), 128'd0);
        check("hold_feat",    feat_vec,          ramp(8'h00));
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        check("hs_m_valid", 128'(bus.m_valid), 128'd0);
        check("hs_s_ready", 128'(bus.s_ready), 128'd1);

        // flush after 5 bytes, coincident byte discarded, then full reload
        send_seq(8'h50, 5);
        flush       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        tick();
        flush       = 1'b0;
        bus.s_valid = 1'b0;
        cls_in = 4'd3;
        send_seq(8'hA0, 15);
        repeat (4) tick();
        check("flush_no_early_result", 128'(bus.m_valid), 128'd0);
        check("flush_s_ready",         128'(bus.s_ready), 128'd1);
        send_seq(8'hAF, 1);
        wait_mvalid("flush_wait");
        check("flush_m_class", 128'(bus.m_class), 128'd3);
        check("flush_feat",    feat_vec,          ramp(8'hA0));
        tick();

        // reset during settle
        send_seq(8'h10, 16);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_settle_feat",    feat_vec,          128'd0);
        check("rst_settle_m_valid", 128'(bus.m_valid), 128'd0);
        check("rst_settle_m_class", 128'(bus.m_class), 128'd0);
        tick();
        tick();
        check("rst_hold_m_valid", 128'(bus.m_valid), 128'd0);
        rst_n = 1'b1;
        tick();
        cls_in = 4'd5;
        send_seq(8'h30, 16);
        wait_mvalid("reload_wait");
        check("reload_m_class", 128'(bus.m_class), 128'd5);
        check("reload_feat",    feat_vec,          ramp(8'h30));
        tick();

        // pseudo-random s_valid gaps, data garbage when not valid
        cls_in = 4'd9;
        k = 0;
        cyc = 0;
        while (k < 16 && cyc < 400) begin
            v = $urandom_range(0, 1);
            bus.s_valid = v[0];
            bus.s_data  = v[0] ? (8'hC0 + 8'(k)) : 8'hFF;
            tick();
            if (v[0]) k++;
            cyc++;
        end
        bus.s_valid = 1'b0;
        check("rand_count", 128'(k), 128'd16);
        wait_mvalid("rand_wait");
        check("rand_feat",    feat_vec,          ramp(8'hC0));
        check("rand_m_class", 128'(bus.m_class), 128'd9);
`ifdef DTREE_LOADER_CLASS_CHECK_EN
        check("err_cls9", 128'(bus.m_err), 128'd0);
        tick();
        cls_in = 4'd12;
        send_seq(8'h00, 16);
        wait_mvalid("err_wait");
        check("err_cls12_class", 128'(bus.m_class), 128'd12);
        check("err_cls12",       128'(bus.m_err),   128'd1);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
